// File: rtl/pe_group_array_if.sv
// pe_group_array_if: bundles the weight, ifmap and psum distribution buses and the
// result collection bus of pe_group_array. Each PE handshakes on its own bit k.
interface pe_group_array_if #(
    parameter int DataWidth     = 32,
    parameter int W_PEGroupSize = 4,
    parameter int O_PEGroupSize = 4,
    parameter int I_PEGroupSize = 7
);
    localparam int NumPe = W_PEGroupSize * O_PEGroupSize;

    logic [NumPe-1:0]                   W_DataInValid;
    logic [NumPe-1:0]                   W_DataInRdy;
    logic [DataWidth*W_PEGroupSize-1:0] W_DataIn;

    logic [NumPe-1:0]                   I_DataInValid;
    logic [NumPe-1:0]                   I_DataInRdy;
    logic [DataWidth*I_PEGroupSize-1:0] I_DataIn;

    logic [NumPe-1:0]                   O_DataInValid;
    logic [NumPe-1:0]                   O_DataInRdy;
    logic [DataWidth*O_PEGroupSize-1:0] O_DataIn;

    logic [NumPe-1:0]                   O_DataOutValid;
    logic [NumPe-1:0]                   O_DataOutRdy;
    logic [DataWidth*NumPe-1:0]         O_DataOut;

    modport master (
        output W_DataInValid, W_DataIn, I_DataInValid, I_DataIn,
        output O_DataInValid, O_DataIn, O_DataOutRdy,
        input  W_DataInRdy, I_DataInRdy, O_DataInRdy, O_DataOutValid, O_DataOut
    );

    modport slave (
        input  W_DataInValid, W_DataIn, I_DataInValid, I_DataIn,
        input  O_DataInValid, O_DataIn, O_DataOutRdy,
        output W_DataInRdy, I_DataInRdy, O_DataInRdy, O_DataOutValid, O_DataOut
    );
endinterface

// File: rtl/pe_group_array.sv
// pe_group_array: row-stationary MAC array. PE(i,j) takes weight lane i, input
// lane i+j and psum lane j, buffers each in its own FIFO and emits
// psum + weight*input on result lane k = j*W_PEGroupSize + i.
// Optional build macro PE_GROUP_SAT_EN: saturate the full-precision result to
// the signed DataWidth range instead of wrapping.
module pe_group_array #(
    parameter int DataWidth     = 32,
    parameter int BufferWidth   = 2,
    parameter int BufferSize    = 4,
    parameter int W_PEGroupSize = 4,
    parameter int O_PEGroupSize = 4,
    parameter int I_PEGroupSize = 7
) (
    input logic             clk,
    input logic             rst,
    pe_group_array_if.slave bus
);
    localparam logic [BufferWidth:0] FullCount = (BufferWidth+1)'(BufferSize);

    for (genvar j = 0; j < O_PEGroupSize; j++) begin : g_row
        for (genvar i = 0; i < W_PEGroupSize; i++) begin : g_col
            localparam int K      = j * W_PEGroupSize + i;
            localparam int InLane = (i + j) % I_PEGroupSize;

            logic [DataWidth-1:0]   w_mem [BufferSize];
            logic [DataWidth-1:0]   x_mem [BufferSize];
            logic [DataWidth-1:0]   p_mem [BufferSize];
            logic [BufferWidth-1:0] w_wr, w_rd, x_wr, x_rd, p_wr, p_rd;
            logic [BufferWidth:0]   w_cnt, x_cnt, p_cnt;
            logic                   w_rdy, x_rdy, p_rdy;
            logic                   w_push, x_push, p_push, fire, out_valid;
            logic [DataWidth-1:0]   w_word, x_word, p_word, result, out_data;

            // Ready comes from registered counts only, so a same-cycle pop never frees a slot.
            assign w_rdy  = w_cnt < FullCount;
            assign x_rdy  = x_cnt < FullCount;
            assign p_rdy  = p_cnt < FullCount;
            assign w_push = bus.W_DataInValid[K] & w_rdy;
            assign x_push = bus.I_DataInValid[K] & x_rdy;
            assign p_push = bus.O_DataInValid[K] & p_rdy;

            assign bus.W_DataInRdy[K] = w_rdy;
            assign bus.I_DataInRdy[K] = x_rdy;
            assign bus.O_DataInRdy[K] = p_rdy;

            assign w_word = w_mem[w_rd];
            assign x_word = x_mem[x_rd];
            assign p_word = p_mem[p_rd];

            assign fire = (|w_cnt) && (|x_cnt) && (|p_cnt) &&
                          (!out_valid || bus.O_DataOutRdy[K]);

            // FIFO storage is left unreset; the pointers alone decide what is valid.
            always_ff @(posedge clk) begin
                if (w_push) w_mem[w_wr] <= bus.W_DataIn[i*DataWidth +: DataWidth];
                if (x_push) x_mem[x_wr] <= bus.I_DataIn[InLane*DataWidth +: DataWidth];
                if (p_push) p_mem[p_wr] <= bus.O_DataIn[j*DataWidth +: DataWidth];
            end

            // Pointer and occupancy bookkeeping for the three operand FIFOs.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    w_wr <= '0; w_rd <= '0; w_cnt <= '0;
                    x_wr <= '0; x_rd <= '0; x_cnt <= '0;
                    p_wr <= '0; p_rd <= '0; p_cnt <= '0;
                end else begin
                    if (w_push) w_wr <= w_wr + 1'b1;
                    if (x_push) x_wr <= x_wr + 1'b1;
                    if (p_push) p_wr <= p_wr + 1'b1;
                    if (fire) begin
                        w_rd <= w_rd + 1'b1;
                        x_rd <= x_rd + 1'b1;
                        p_rd <= p_rd + 1'b1;
                    end
                    if (w_push && !fire)      w_cnt <= w_cnt + 1'b1;
                    else if (!w_push && fire) w_cnt <= w_cnt - 1'b1;
                    if (x_push && !fire)      x_cnt <= x_cnt + 1'b1;
                    else if (!x_push && fire) x_cnt <= x_cnt - 1'b1;
                    if (p_push && !fire)      p_cnt <= p_cnt + 1'b1;
                    else if (!p_push && fire) p_cnt <= p_cnt - 1'b1;
                end
            end

`ifdef PE_GROUP_SAT_EN
            localparam logic signed [2*DataWidth:0] MaxVal =
                (2*DataWidth+1)'($signed({1'b0, {(DataWidth-1){1'b1}}}));
            localparam logic signed [2*DataWidth:0] MinVal =
                (2*DataWidth+1)'($signed({1'b1, {(DataWidth-1){1'b0}}}));
            logic signed [2*DataWidth:0] wide;

            // Full-precision multiply-accumulate, clamped to the signed word range.
            always_comb begin
                wide = (2*DataWidth+1)'($signed(w_word)) * (2*DataWidth+1)'($signed(x_word))
                     + (2*DataWidth+1)'($signed(p_word));
                if (wide > MaxVal)      result = {1'b0, {(DataWidth-1){1'b1}}};
                else if (wide < MinVal) result = {1'b1, {(DataWidth-1){1'b0}}};
                else                    result = wide[DataWidth-1:0];
            end
`else
            // Two's complement multiply-accumulate keeping only the low word.
            always_comb begin
                result = p_word + w_word * x_word;
            end
`endif

            // Result register: a new fire replaces the held value, an accept alone drops valid.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    out_valid <= 1'b0;
                    out_data  <= '0;
                end else if (fire) begin
                    out_valid <= 1'b1;
                    out_data  <= result;
                end else if (bus.O_DataOutRdy[K]) begin
                    out_valid <= 1'b0;
                end
            end

            assign bus.O_DataOutValid[K]                 = out_valid;
            assign bus.O_DataOut[K*DataWidth +: DataWidth] = out_data;
        end
    end
endmodule

// File: tb/tb_pe_group_array.sv
// tb_pe_group_array: directed scoreboard bench for pe_group_array. Expected
// results are queued per PE when operands are driven and compared when the
// PE presents a result. Inputs change and outputs are sampled on the falling edge.
module tb_pe_group_array;
    localparam int DataWidth = 32;
    localparam int WSize     = 4;
    localparam int OSize     = 4;
    localparam int ISize     = 7;
    localparam int NumPe     = WSize * OSize;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic [DataWidth-1:0] exp_q [NumPe][$];

    pe_group_array_if #(
        .DataWidth(DataWidth), .W_PEGroupSize(WSize),
        .O_PEGroupSize(OSize), .I_PEGroupSize(ISize)
    ) bus ();

    pe_group_array #(
        .DataWidth(DataWidth), .BufferWidth(2), .BufferSize(4),
        .W_PEGroupSize(WSize), .O_PEGroupSize(OSize), .I_PEGroupSize(ISize)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [511:0] observed,
                               input logic [511:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] w, input logic [31:0] x,
                                          input logic [31:0] p);
`ifdef PE_GROUP_SAT_EN
        longint full;
        full = longint'($signed(w)) * longint'($signed(x)) + longint'($signed(p));
        if (full > 64'sh7FFFFFFF)               return 32'h7FFFFFFF;
        else if (full < -64'sh80000000)         return 32'h80000000;
        else                                    return full[31:0];
`else
        return p + w * x;
`endif
    endfunction

    // Put one operand set on the lanes PE k reads and raise its three valid bits.
    task automatic applyStimulus(input int k, input logic [31:0] w, input logic [31:0] x,
                                 input logic [31:0] p);
        int i = k % WSize;
        int j = k / WSize;
        bus.W_DataIn[i*DataWidth +: DataWidth]     = w;
        bus.I_DataIn[(i+j)*DataWidth +: DataWidth] = x;
        bus.O_DataIn[j*DataWidth +: DataWidth]     = p;
        bus.W_DataInValid[k] = 1'b1;
        bus.I_DataInValid[k] = 1'b1;
        bus.O_DataInValid[k] = 1'b1;
    endtask

    task automatic pushOp(input int k, input logic [31:0] w, input logic [31:0] x,
                          input logic [31:0] p);
        applyStimulus(k, w, x, p);
        exp_q[k].push_back(model(w, x, p));
    endtask

    task automatic clearValids();
        bus.W_DataInValid = '0;
        bus.I_DataInValid = '0;
        bus.O_DataInValid = '0;
    endtask

    // Wait up to budget falling edges for PE k's result, score it, then accept it for one edge.
    task automatic collect(input int k, input int budget, input string tag);
        logic found = 1'b0;
        logic [31:0] expected;
        for (int n = 0; n <= budget && !found; n++) begin
            if (n != 0) @(negedge clk);
            found = bus.O_DataOutValid[k];
        end
        if (!found) begin
            checkOutput({tag, "_timeout"}, 512'(found), 512'(1));
        end else if (exp_q[k].size() == 0) begin
            checkOutput({tag, "_unexpected"}, 512'(exp_q[k].size()), 512'(1));
        end else begin
            expected = exp_q[k].pop_front();
            checkOutput(tag, 512'(bus.O_DataOut[k*DataWidth +: DataWidth]), 512'(expected));
            bus.O_DataOutRdy[k] = 1'b1;
            @(negedge clk);
            bus.O_DataOutRdy[k] = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b0;
        clearValids();
        bus.W_DataIn     = '0;
        bus.I_DataIn     = '0;
        bus.O_DataIn     = '0;
        bus.O_DataOutRdy = '0;

        // Reset held with random valids: nothing may enter or emerge.
        @(negedge clk);
        bus.W_DataInValid = 16'($urandom);
        bus.I_DataInValid = 16'($urandom);
        bus.O_DataInValid = 16'($urandom);
        bus.W_DataIn      = 128'({$urandom, $urandom, $urandom, $urandom});
        repeat (3) @(negedge clk);
        checkOutput("reset_valid", 512'(bus.O_DataOutValid), 512'(0));
        checkOutput("reset_data", bus.O_DataOut, 512'(0));
        checkOutput("reset_rdy", 512'({bus.W_DataInRdy, bus.I_DataInRdy, bus.O_DataInRdy}),
                    512'({48{1'b1}}));
        clearValids();
        rst = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            checkOutput($sformatf("post_reset_quiet%0d", n), 512'(bus.O_DataOutValid), 512'(0));
        end

        // Single PE(0,0): 10 + 3*5 = 25, visible two edges after the push.
        pushOp(0, 32'd3, 32'd5, 32'd10);
        @(negedge clk);
        clearValids();
        checkOutput("single_not_yet", 512'(bus.O_DataOutValid), 512'(0));
        @(negedge clk);
        checkOutput("single_valid_mask", 512'(bus.O_DataOutValid), 512'(16'h0001));
        collect(0, 0, "single_result");

        // Diagonal sharing of input lane 3 across PEs 3, 6, 9, 12.
        pushOp(3,  32'd1, 32'd2, 32'd0);
        pushOp(6,  32'd2, 32'd2, 32'd0);
        pushOp(9,  32'd3, 32'd2, 32'd0);
        pushOp(12, 32'd4, 32'd2, 32'd0);
        @(negedge clk);
        clearValids();
        @(negedge clk);
        checkOutput("diag_valid_mask", 512'(bus.O_DataOutValid), 512'(16'h1248));
        collect(3,  0, "diag_pe3");
        collect(6,  0, "diag_pe6");
        collect(9,  0, "diag_pe9");
        collect(12, 0, "diag_pe12");

        // Backpressure: five sets enter PE0 (one fires, four buffer), the sixth is refused.
        for (int n = 0; n < 5; n++) begin
            pushOp(0, 32'(n + 1), 32'd7, 32'(100 * n));
            @(negedge clk);
        end
        applyStimulus(0, 32'd99, 32'd99, 32'd99);
        checkOutput("full_w_rdy", 512'(bus.W_DataInRdy[0]), 512'(0));
        checkOutput("full_i_rdy", 512'(bus.I_DataInRdy[0]), 512'(0));
        checkOutput("full_o_rdy", 512'(bus.O_DataInRdy[0]), 512'(0));
        @(negedge clk);
        clearValids();
        for (int n = 0; n < 5; n++) collect(0, 0, $sformatf("drain%0d", n));
        checkOutput("drain_valid_clear", 512'(bus.O_DataOutValid[0]), 512'(0));
        checkOutput("drain_rdy_back", 512'(bus.W_DataInRdy[0]), 512'(1));

        // Overflowing product: wraps to 1, or clamps to max positive when saturating.
        pushOp(5, 32'h7FFFFFFF, 32'd2, 32'd3);
        @(negedge clk);
        clearValids();
        collect(5, 4, "wrap_result");
        pushOp(5, 32'hFFFFFFFD, 32'd4, 32'd5);
        @(negedge clk);
        clearValids();
        collect(5, 4, "signed_result");

        // Asynchronous reset between edges while PE15 holds a result and two buffered sets.
        for (int n = 0; n < 3; n++) begin
            pushOp(15, 32'(n + 2), 32'd3, 32'd1);
            @(negedge clk);
        end
        clearValids();
        #2 rst = 1'b0;
        #1;
        checkOutput("midrst_valid", 512'(bus.O_DataOutValid), 512'(0));
        checkOutput("midrst_data", bus.O_DataOut, 512'(0));
        checkOutput("midrst_rdy", 512'({bus.W_DataInRdy, bus.I_DataInRdy, bus.O_DataInRdy}),
                    512'({48{1'b1}}));
        exp_q[15].delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        pushOp(15, 32'd7, 32'd6, 32'd1);
        @(negedge clk);
        clearValids();
        collect(15, 4, "after_reset_result");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pe_group_array.md
Name:
pe_group_array

Overview:
- Two-dimensional MAC processing-element array in row-stationary arrangement: W_PEGroupSize PEs per row (index i) by O_PEGroupSize rows (index j).
- PE(i,j), flat index k = j*W_PEGroupSize + i, consumes weight lane i, input lane i+j (diagonal sharing) and psum lane j.
- Each PE emits psum + weight*input on its own output lane.
- Sits between the weight, ifmap and psum distribution buses and the psum collection network.

Parameters:
- DataWidth, 32, bit width of every data word.
- BufferWidth, 2, FIFO pointer width; must equal log2(BufferSize).
- BufferSize, 4, depth of each per-PE input FIFO; power of two, at least 2.
- W_PEGroupSize, 4, PEs per row (weight lanes).
- O_PEGroupSize, 4, PE rows (psum lanes).
- I_PEGroupSize, 7, input lanes; must equal W_PEGroupSize+O_PEGroupSize-1.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous active-low reset.
- W_DataInValid  in  O*W  per-PE weight valid, bit k.
- W_DataInRdy  out  O*W  per-PE weight ready, bit k.
- W_DataIn  in  DataWidth*W  weight lanes; lane i = bits [i*DataWidth +: DataWidth].
- I_DataInValid  in  O*W  per-PE input valid.
- I_DataInRdy  out  O*W  per-PE input ready.
- I_DataIn  in  DataWidth*I  input lanes; PE(i,j) reads lane i+j.
- O_DataInValid  in  O*W  per-PE psum-in valid.
- O_DataInRdy  out  O*W  per-PE psum-in ready.
- O_DataIn  in  DataWidth*O  psum lanes; PE(i,j) reads lane j.
- O_DataOutValid  out  O*W  per-PE result valid.
- O_DataOutRdy  in  O*W  per-PE result ready.
- O_DataOut  out  DataWidth*O*W  results; lane k = PE(i,j).

Behaviour:
- Each PE has three FIFOs (weight, input, psum), each BufferSize deep with BufferWidth-bit read/write pointers and a (BufferWidth+1)-bit count.
- FIFO ready is registered-state derived: XxRdy[k] = (count < BufferSize), i.e. high whenever the FIFO is not full.
- A word is pushed when Valid[k] & Rdy[k] on a clock edge. Data is sampled that edge.
- One lane may feed several PEs. Each PE handshakes independently through its own bit k.
- No write while full, even if the same cycle pops. Ready depends only on registered count, never combinationally on a pop.
- Pointers wrap modulo BufferSize. Simultaneous push and pop keeps count unchanged.
- Fire condition per PE: all three FIFOs non-empty AND (O_DataOutValid[k]==0 OR O_DataOutRdy[k]==1).
- On fire:
  - pop one word from each FIFO;
  - register result = psum + weight*input into O_DataOut lane k;
  - set O_DataOutValid[k].
- Arithmetic is two's complement signed. Product and sum are truncated to the low DataWidth bits (wrap-around).
- Output register holds value and valid until O_DataOutRdy[k] is sampled high.
  - If fire and accept coincide, the new result replaces the old and valid stays 1.
  - Accept without fire clears valid.
- Latency: last operand pushed at edge N, then fire at edge N+1, then O_DataOutValid high after edge N+1. Two clock edges from last push to visible result.
- Throughput: one result per PE per cycle with continuously available operands.
- Operands pair strictly in FIFO order. No reordering across PEs.
- Reset (rst=0, asynchronous):
  - all counts and pointers to 0;
  - all O_DataOutValid 0, all O_DataOut 0;
  - all Rdy outputs 1 once FIFOs are empty.
- Reset mid-operation discards all buffered operands and pending results. FIFO storage contents need not be cleared.

Optional Feature:
- Macro PE_GROUP_SAT_EN.
- Defined: compute full-precision signed product plus psum, then clamp to [-2^(DataWidth-1), 2^(DataWidth-1)-1] before registering.
- Undefined: wrap-around truncation as above.
- Handshake and latency are identical in both builds.

Test Plan:
- Reset: hold rst=0 with random valids → all O_DataOutValid=0, O_DataOut=0, all Rdy=1. Release → no spurious results.
- Single PE(0,0):
  - Push W lane0=3, I lane0=5, O lane0=10, bit 0 only → O_DataOut lane0=25, valid 2 edges after last push.
  - Other 15 valid bits stay 0.
- Diagonal sharing: I lane3=2 to PE(3,0), PE(2,1), PE(1,2), PE(0,3); weights 1,2,3,4; psums 0 → results 2,4,6,8 on lanes 3,6,9,12.
- Backpressure and full:
  - O_DataOutRdy[0]=0; push 6 operand sets to PE0 → one result held, 4 buffered, W/I/O_DataInRdy[0]=0.
  - Release ready → results drain one per cycle, in order.
- Wrap arithmetic: weight=0x7FFFFFFF, input=2, psum=3 → 0x00000001. With PE_GROUP_SAT_EN → 0x7FFFFFFF.
- Async reset mid-stream: assert rst between edges while 3 words are buffered → valids drop immediately, Rdy=1 after reset, next fresh operands give the correct result.
